uart_rx_fifo: RTL and testbench

Parametrised UART receiver with an output FIFO. It decodes the serial `tx` line of the DUT, or an external serial input on the board, into bytes and queues them with per-byte error flags for a consumer: a bench monitor or the core's I/O peripheral. It is the successor of the fixed 8N1 bench-side line watching. Frame format, baud divisor and buffer depth are generalised, and it adds error detection and overflow reporting.

---
 rtl/uart_rx_fifo.sv | 189 ++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling FSM and a
// show-ahead FIFO of {ferr, perr, data} entries with sticky overflow.
module uart_rx_fifo #(
    parameter int ClkFreq    = 50_000_000,
    parameter int BaudRate   = 115_200,
    parameter int DataBits   = 8,
    parameter int ParityMode = 0,
    parameter int StopBits   = 1,
    parameter int FifoDepth  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         rx_i,
    input  logic                         rd_en_i,
    output logic [DataBits-1:0]          data_o,
    output logic                         perr_o,
    output logic                         ferr_o,
    output logic                         empty_o,
    output logic                         full_o,
    output logic [$clog2(FifoDepth):0]   count_o,
    output logic                         overflow_o,
    input  logic                         clr_ovf_i
);

    localparam int Div  = ClkFreq / BaudRate;
    localparam int Half = Div / 2;
    localparam int CW   = $clog2(Div);
    localparam int AW   = $clog2(FifoDepth);
    localparam int EW   = DataBits + 2;

    localparam logic [CW-1:0] CntMax   = CW'(Div - 1);
    localparam logic [CW-1:0] CntMid   = CW'(Half);
    localparam logic [3:0]    LastData = 4'(DataBits - 1);
    localparam logic [3:0]    LastStop = 4'(StopBits - 1);
    localparam logic          HasPar   = (ParityMode != 0);
    localparam logic          OddPar   = (ParityMode == 1);
    localparam logic [AW:0]   CntFull  = (AW+1)'(FifoDepth);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e              state_q;
    logic                rx_m_q;
    logic                rx_s_q;
    logic [CW-1:0]       baud_q;
    logic [3:0]          bit_q;
    logic [DataBits-1:0] sh_q;
    logic                perr_q;
    logic                ferr_q;
    logic                brk_q;

    logic                mid;
    logic                push;
    logic [EW-1:0]       push_ent;

    assign mid      = (baud_q == CntMid);
    assign push     = (state_q == S_STOP) && mid && (bit_q == LastStop);
    assign push_ent = {ferr_q | ~rx_s_q, perr_q, sh_q};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_m_q  <= 1'b1;
            rx_s_q  <= 1'b1;
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            brk_q   <= 1'b0;
        end else begin
            rx_m_q <= rx_i;
            rx_s_q <= rx_m_q;
            if (state_q != S_IDLE) begin
                baud_q <= (baud_q == CntMax) ? '0 : baud_q + 1'b1;
            end
            unique case (state_q)
                S_IDLE: begin
                    baud_q <= '0;
                    bit_q  <= '0;
                    // after a framing error the line must go idle before a new start
                    if (brk_q) begin
                        if (rx_s_q) brk_q <= 1'b0;
                    end else if (!rx_s_q) begin
                        state_q <= S_START;
                        perr_q  <= 1'b0;
                        ferr_q  <= 1'b0;
                    end
                end
                S_START: begin
                    if (mid) state_q <= rx_s_q ? S_IDLE : S_DATA;
                end
                S_DATA: begin
                    if (mid) begin
                        sh_q <= {rx_s_q, sh_q[DataBits-1:1]};
                        if (bit_q == LastData) begin
                            bit_q   <= '0;
                            state_q <= HasPar ? S_PARITY : S_STOP;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (mid) begin
                        perr_q  <= ((^sh_q) ^ rx_s_q) != OddPar;
                        state_q <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (mid) begin
                        if (bit_q == LastStop) begin
                            bit_q   <= '0;
                            brk_q   <= ferr_q | ~rx_s_q;
                            state_q <= S_IDLE;
                        end else begin
                            bit_q  <= bit_q + 1'b1;
                            ferr_q <= ferr_q | ~rx_s_q;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    logic [EW-1:0] mem_q [FifoDepth];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          do_pop;
    logic          do_push;
    logic          drop;
    logic [EW-1:0] head;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CntFull);
    assign do_pop  = rd_en_i & ~empty_o;
    // a pop on the same edge frees the slot, so a full FIFO still accepts
    assign do_push = push & (~full_o | do_pop);
    assign drop    = push & full_o & ~do_pop;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf_i) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_ent;
    end

    assign head       = mem_q[rd_q];
    assign data_o     = empty_o ? '0 : head[DataBits-1:0];
    assign perr_o     = ~empty_o & head[DataBits];
    assign ferr_o     = ~empty_o & head[DataBits+1];
    assign count_o    = cnt_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: u0 is 8N1 depth 4, u1 is 8E2 depth 16.
// A queue model predicts FIFO outputs every cycle from the frames sent.
module tb_uart_rx_fifo;

    localparam int Div = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic [1:0] rx    = 2'b11;
    logic [1:0] rd    = 2'b00;
    logic [1:0] clr   = 2'b00;

    logic [7:0] dat0, dat1;
    logic [2:0] cnt0;
    logic [4:0] cnt1;
    logic [1:0] perr, ferr, empty, full, ovf;
    logic [7:0] dat_a [2];
    logic [4:0] cnt_a [2];

    assign dat_a[0] = dat0;
    assign dat_a[1] = dat1;
    assign cnt_a[0] = {2'b00, cnt0};
    assign cnt_a[1] = cnt1;

    uart_rx_fifo #(
        .ClkFreq(1_000_000), .BaudRate(100_000), .DataBits(8),
        .ParityMode(0), .StopBits(1), .FifoDepth(4)
    ) u0 (
        .clk(clk), .reset(reset), .rx_i(rx[0]), .rd_en_i(rd[0]),
        .data_o(dat0), .perr_o(perr[0]), .ferr_o(ferr[0]),
        .empty_o(empty[0]), .full_o(full[0]), .count_o(cnt0),
        .overflow_o(ovf[0]), .clr_ovf_i(clr[0])
    );

    uart_rx_fifo #(
        .ClkFreq(1_000_000), .BaudRate(100_000), .DataBits(8),
        .ParityMode(2), .StopBits(2), .FifoDepth(16)
    ) u1 (
        .clk(clk), .reset(reset), .rx_i(rx[1]), .rd_en_i(rd[1]),
        .data_o(dat1), .perr_o(perr[1]), .ferr_o(ferr[1]),
        .empty_o(empty[1]), .full_o(full[1]), .count_o(cnt1),
        .overflow_o(ovf[1]), .clr_ovf_i(clr[1])
    );

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, int unsigned act, int unsigned exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endfunction

    function automatic int dep(int i);
        return (i == 0) ? 4 : 16;
    endfunction

    // model: FIFO contents, sticky overflow, and pending pushes {edge, entry}
    logic [9:0] mq    [2][$];
    int         sq_c  [2][$];
    logic [9:0] sq_e  [2][$];
    logic       movf  [2];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                mq[i].delete();
                sq_c[i].delete();
                sq_e[i].delete();
                movf[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                int         sb;
                bit         ps, pp, dr;
                logic [9:0] pe;
                sb = mq[i].size();
                ps = 1'b0;
                pe = '0;
                if (sq_c[i].size() > 0 && sq_c[i][0] == cyc + 1) begin
                    ps = 1'b1;
                    pe = sq_e[i].pop_front();
                    void'(sq_c[i].pop_front());
                end
                pp = rd[i] && (sb > 0);
                dr = ps && (sb == dep(i)) && !pp;
                if (pp) void'(mq[i].pop_front());
                if (ps && !dr) mq[i].push_back(pe);
                if (dr) movf[i] = 1'b1;
                else if (clr[i]) movf[i] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int n;
            n = mq[i].size();
            chk($sformatf("u%0d.empty", i), empty[i], n == 0);
            chk($sformatf("u%0d.full", i), full[i], n == dep(i));
            chk($sformatf("u%0d.count", i), cnt_a[i], n);
            chk($sformatf("u%0d.ovf", i), ovf[i], movf[i]);
            if (n > 0) begin
                chk($sformatf("u%0d.data", i), dat_a[i], mq[i][0][7:0]);
                chk($sformatf("u%0d.perr", i), perr[i], mq[i][0][8]);
                chk($sformatf("u%0d.ferr", i), ferr[i], mq[i][0][9]);
            end
        end
    end

    // Drives one frame on rx[i]; u1 adds even parity bit pb and second stop s1.
    // The write edge is 2 sync flops + 1 idle-detect cycle + mid-bit count
    // + 1 after the start edge, plus Div per bit before the last stop bit.
    task automatic send(input int i, input logic [7:0] d, input logic pb,
                        input logic s0, input logic s1, input bit abort,
                        input int gap);
        logic       b [$];
        logic [9:0] e;
        int         c0;
        b.push_back(1'b0);
        for (int k = 0; k < 8; k++) b.push_back(d[k]);
        if (i == 1) b.push_back(pb);
        b.push_back(s0);
        if (i == 1) b.push_back(s1);
        c0 = cyc;
        if (!abort) begin
            e[7:0] = d;
            e[8]   = (i == 1) ? (((^d) ^ pb) != 1'b0) : 1'b0;
            e[9]   = !s0 || (i == 1 && !s1);
            sq_c[i].push_back(c0 + 3 + Div / 2 + 1 + Div * (b.size() - 1));
            sq_e[i].push_back(e);
        end
        for (int k = 0; k < b.size(); k++) begin
            rx[i] = b[k];
            if (abort && k == 4) begin
                repeat (Div / 2) @(posedge clk);
                #1;
                return;
            end
            repeat (Div) @(posedge clk);
            #1;
        end
        rx[i] = 1'b1;
        repeat (gap) @(posedge clk);
        #1;
    endtask

    task automatic pop(input int i);
        rd[i] = 1'b1;
        @(posedge clk);
        #1;
        rd[i] = 1'b0;
    endtask

    task automatic rand_run(input int i, input int n);
        bit done;
        int sent;
        done = 1'b0;
        sent = 0;
        fork
            begin
                for (int k = 0; k < n; k++) begin
                    logic [7:0] d;
                    logic       pb, s0, s1;
                    d  = 8'($urandom);
                    pb = 1'($urandom);
                    s0 = ($urandom_range(0, 7) != 0);
                    s1 = ($urandom_range(0, 7) != 0);
                    send(i, d, pb, s0, s1, 1'b0, 2 + $urandom_range(0, 4));
                    sent++;
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    rd[i]  = ($urandom_range(0, (sent < n / 2) ? 150 : 6) == 0);
                    clr[i] = ($urandom_range(0, 300) == 0);
                    @(posedge clk);
                    #1;
                end
                rd[i]  = 1'b0;
                clr[i] = 1'b0;
            end
        join
    endtask

    initial begin
        int c0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.empty", empty[0], 1);
        chk("rst.full", full[0], 0);
        chk("rst.count", cnt0, 0);
        chk("rst.ovf", ovf[0], 0);
        chk("rst.data", dat0, 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 8N1 0xA5 and its push latency
        c0 = cyc;
        fork
            send(0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 2);
            begin
                repeat (98) @(posedge clk);
                @(negedge clk);
                chk("lat.pre", empty[0], 1);
                @(posedge clk);
                @(negedge clk);
                chk("lat.post", empty[0], 0);
            end
        join
        chk("a5.data", dat0, 8'hA5);
        chk("a5.perr", perr[0], 0);
        chk("a5.ferr", ferr[0], 0);
        pop(0);
        chk("a5.empty", empty[0], 1);
        chk("a5.count", cnt0, 0);

        // short low glitch is rejected
        rx[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx[0] = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("glitch.count", cnt0, 0);
        send(0, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 2);
        chk("3c.data", dat0, 8'h3C);
        pop(0);

        // even parity: 0x07 has odd weight, so parity bit 1 is correct
        send(1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 2);
        chk("par1.perr", perr[1], 0);
        pop(1);
        send(1, 8'h07, 1'b0, 1'b1, 1'b1, 1'b0, 2);
        chk("par0.perr", perr[1], 1);
        pop(1);
        send(1, 8'h42, 1'b0, 1'b1, 1'b0, 1'b0, 4);
        chk("stop2.ferr", ferr[1], 1);
        pop(1);
        send(1, 8'h81, 1'b0, 1'b1, 1'b1, 1'b0, 2);
        chk("brk.data", dat1, 8'h81);
        chk("brk.ferr", ferr[1], 0);
        pop(1);

        // overflow on depth 4
        for (int k = 1; k <= 5; k++) send(0, 8'(k), 1'b0, 1'b1, 1'b1, 1'b0, 2);
        chk("ovf.full", full[0], 1);
        chk("ovf.count", cnt0, 4);
        chk("ovf.flag", ovf[0], 1);
        for (int k = 1; k <= 4; k++) begin
            chk("ovf.pop", dat0, k);
            pop(0);
        end
        clr[0] = 1'b1;
        @(posedge clk);
        #1;
        clr[0] = 1'b0;
        chk("ovf.clr", ovf[0], 0);

        // push while full with a pop on the same edge
        for (int k = 0; k < 4; k++) send(0, 8'h11 + 8'(k), 1'b0, 1'b1, 1'b1, 1'b0, 2);
        fork
            send(0, 8'h06, 1'b0, 1'b1, 1'b1, 1'b0, 2);
            begin
                repeat (98) @(posedge clk);
                #1;
                rd[0] = 1'b1;
                @(posedge clk);
                #1;
                rd[0] = 1'b0;
            end
        join
        chk("fp.count", cnt0, 4);
        chk("fp.ovf", ovf[0], 0);
        chk("fp.head", dat0, 8'h12);
        for (int k = 0; k < 3; k++) pop(0);
        chk("fp.last", dat0, 8'h06);
        pop(0);

        // reset in the middle of a frame
        for (int k = 0; k < 5; k++) send(0, 8'h99 - 8'(k), 1'b0, 1'b1, 1'b1, 1'b0, 2);
        send(0, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b1, 0);
        reset = 1'b1;
        #1;
        chk("mr.empty", empty[0], 1);
        chk("mr.full", full[0], 0);
        chk("mr.count", cnt0, 0);
        chk("mr.ovf", ovf[0], 0);
        chk("mr.data", dat0, 0);
        rx[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        send(0, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 2);
        chk("mr.5a", dat0, 8'h5A);
        chk("mr.cnt", cnt0, 1);
        pop(0);

        fork
            rand_run(0, 40);
            rand_run(1, 40);
        join
        repeat (20) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
